spi_sink: RTL and testbench

SPI_SINK -- requirements
Module: spi_sink

---
 rtl/spi_sink_pkg.sv | 17 +
 rtl/spi_sink_fifo.sv | 61 ++++++
 rtl/spi_sink.sv | 166 ++++++++++++++++
 tb/tb_spi_sink.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sink_pkg.sv
// -----------------------------------------------------------------------------
// spi_sink_pkg
// Shared definitions for the SPI byte sink: receive FSM state encoding,
// byte width and synchronizer depth.
// -----------------------------------------------------------------------------
package spi_sink_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int BYTE_W      = 8;
   localparam int SYNC_STAGES = 2;
   localparam int BIT_CNT_W   = $clog2(BYTE_W);

endpackage : spi_sink_pkg

// File: rtl/spi_sink_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO with a valid/ready pop side.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i          : write request for push_data_i
//   push_data_i     : data to store
//   push_accept_o   : the write request is actually stored this cycle
//   pop_ready_i     : consumer takes the head entry (only while pop_valid_o)
//   pop_valid_o     : FIFO non-empty
//   pop_data_o      : head entry, forced to zero while empty
//   full_o, empty_o : occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic             push_accept_o,
   input  logic             pop_ready_i,
   output logic             pop_valid_o,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             pop;

   // Extra pointer MSB tells a wrapped (full) FIFO from an empty one.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign pop           = pop_ready_i & ~empty_o;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push_accept_o = push_i & (~full_o | pop);

   assign pop_valid_o = ~empty_o;
   assign pop_data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_accept_o) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)           rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_accept_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule : sync_fifo

// File: rtl/spi_sink.sv
// -----------------------------------------------------------------------------
// spi_sink
// SPI mode-0 receive-only slave. Bytes assembled from MOSI are queued in a
// small FIFO and handed to the consumer with valid/ready.
//   clk, rst_n              : system clock, asynchronous active-low reset
//   sclk_in, mosi_in, cs_n_in : raw SPI pins (asynchronous to clk)
//   rx_ready                : consumer takes rx_data this cycle
//   clr_flags               : clear overflow and frame_err
//   rx_data, rx_valid       : FIFO head byte and non-empty flag
//   busy                    : frame in progress
//   overflow, frame_err     : sticky error flags
//   byte_count              : bytes accepted into the FIFO, modulo 256
// -----------------------------------------------------------------------------
module spi_sink
   import spi_sink_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk_in,
   input  logic              mosi_in,
   input  logic              cs_n_in,
   input  logic              rx_ready,
   input  logic              clr_flags,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              overflow,
   output logic              frame_err,
   output logic [7:0]        byte_count
);

   // ---------------- synchronizers and edge detection ----------------
   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
   logic sclk_s, mosi_s, cs_s;
   logic sclk_prev_q, cs_prev_q;
   logic sclk_rise_q, cs_fall_q, cs_rise_q, mosi_dly_q;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];

   // Edge pulses are registered; mosi is delayed by the same stage so the
   // sampled data bit stays aligned with its sclk edge pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         sclk_rise_q <= 1'b0;
         cs_fall_q   <= 1'b0;
         cs_rise_q   <= 1'b0;
         mosi_dly_q  <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
         sclk_rise_q <= sclk_s & ~sclk_prev_q;
         cs_fall_q   <= ~cs_s & cs_prev_q;
         cs_rise_q   <= cs_s & ~cs_prev_q;
         mosi_dly_q  <= mosi_s;
      end
   end

   // ---------------- receive FSM ----------------
   state_t               state_q, state_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0]    shreg_q, shreg_d;
   logic                 push, frame_err_set;

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shreg_d       = shreg_q;
      push          = 1'b0;
      frame_err_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall_q) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
               shreg_d   = '0;
            end
         end
         SHIFT: begin
            // sclk is handled before cs_n so a coincident final bit still counts.
            if (sclk_rise_q) begin
               if (MSB_FIRST != 0) shreg_d = {shreg_q[BYTE_W-2:0], mosi_dly_q};
               else                shreg_d = {mosi_dly_q, shreg_q[BYTE_W-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;   // wraps to 0 after the last bit
               if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) push = 1'b1;
            end
            if (cs_rise_q) begin
               state_d = IDLE;
               if (bit_cnt_d != '0) frame_err_set = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
      end
   end

   // ---------------- FIFO, flags and counter ----------------
   logic push_accept, fifo_full, fifo_empty;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (BYTE_W)
   ) u_fifo (
      .clk           (clk),
      .rst_n         (rst_n),
      .push_i        (push),
      .push_data_i   (shreg_d),
      .push_accept_o (push_accept),
      .pop_ready_i   (rx_ready),
      .pop_valid_o   (rx_valid),
      .pop_data_o    (rx_data),
      .full_o        (fifo_full),
      .empty_o       (fifo_empty)
   );

   logic       overflow_q, overflow_d, frame_err_q, frame_err_d;
   logic [7:0] byte_count_q, byte_count_d;

   // Set wins over a coincident clear.
   always_comb begin
      overflow_d   = (push & ~push_accept) | (overflow_q & ~clr_flags);
      frame_err_d  = frame_err_set | (frame_err_q & ~clr_flags);
      byte_count_d = byte_count_q + (push_accept ? 8'd1 : 8'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         byte_count_q <= '0;
      end else begin
         overflow_q   <= overflow_d;
         frame_err_q  <= frame_err_d;
         byte_count_q <= byte_count_d;
      end
   end

   assign busy       = (state_q == SHIFT);
   assign overflow   = overflow_q;
   assign frame_err  = frame_err_q;
   assign byte_count = byte_count_q;

endmodule : spi_sink

// File: tb/tb_spi_sink.sv
module tb_spi_sink;

   logic       clk = 1'b0;
   logic       rst_n, sclk_in, mosi_in, cs_n_in, rx_ready, clr_flags;
   logic [7:0] rx_data, byte_count;
   logic       rx_valid, busy, overflow, frame_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   spi_sink #(.DEPTH(4), .MSB_FIRST(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sclk_in    (sclk_in),
      .mosi_in    (mosi_in),
      .cs_n_in    (cs_n_in),
      .rx_ready   (rx_ready),
      .clr_flags  (clr_flags),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .busy       (busy),
      .overflow   (overflow),
      .frame_err  (frame_err),
      .byte_count (byte_count)
   );

   // Record every byte the consumer takes (handshake seen between edges).
   logic [7:0] popped[$];
   always @(negedge clk) begin
      if (rst_n && rx_valid && rx_ready) popped.push_back(rx_data);
   end

   typedef struct {
      logic [7:0] data;
      logic [7:0] exp_count;
   } vec_t;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; sclk_in = 1'b0; mosi_in = 1'b0; cs_n_in = 1'b1;
      rx_ready = 1'b0; clr_flags = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
   endtask

   // One byte MSB first, sclk period 8 clk; optional pop aligned with the
   // cycle the 8th bit is pushed (4 clk after the raw rising edge).
   task automatic send_byte(input logic [7:0] b, input bit pop_on_last);
      for (int i = 7; i >= 0; i--) begin
         mosi_in = b[i];
         tick(4);
         sclk_in = 1'b1;
         if (i == 0 && pop_on_last) begin
            tick(3);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
         end else begin
            tick(4);
         end
         sclk_in = 1'b0;
      end
   endtask

   task automatic cs_low();
      cs_n_in = 1'b0;
      tick(4);
   endtask

   task automatic cs_high();
      cs_n_in = 1'b1;
      tick(6);
   endtask

   task automatic pop_one();
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{data: 8'h5A, exp_count: 8'd2};
      vecs[1] = '{data: 8'hFF, exp_count: 8'd3};
      vecs[2] = '{data: 8'h00, exp_count: 8'd4};
      vecs[3] = '{data: 8'h81, exp_count: 8'd5};

      // ---- reset state ----
      rst_n = 1'b0; sclk_in = 1'b0; mosi_in = 1'b0; cs_n_in = 1'b1;
      rx_ready = 1'b0; clr_flags = 1'b0;
      tick(3);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_flags", {overflow, frame_err}, 0);
      check("rst_count", byte_count, 0);
      rst_n = 1'b1;
      tick(2);

      // ---- 0xA5 with latency measurement ----
      cs_low();
      check("a5_busy", busy, 1);
      for (int i = 7; i >= 1; i--) begin
         mosi_in = 8'hA5 >> i;
         tick(4); sclk_in = 1'b1; tick(4); sclk_in = 1'b0;
      end
      mosi_in = 1'b1;
      tick(4);
      sclk_in = 1'b1;
      tick(3);
      check("a5_valid_at_3", rx_valid, 0);
      tick(1);
      check("a5_valid_at_4", rx_valid, 1);
      tick(4); sclk_in = 1'b0;
      cs_high();
      $display("[TB] frame 0xa5 -> rx_data=0x%0h count=%0d", rx_data, byte_count);
      check("a5_data", rx_data, 8'hA5);
      check("a5_count", byte_count, 1);
      check("a5_frame_err", frame_err, 0);
      check("a5_busy_end", busy, 0);
      pop_one();
      check("a5_popped", rx_valid, 0);

      // ---- table of single-byte frames ----
      foreach (vecs[k]) begin
         cs_low();
         send_byte(vecs[k].data, 1'b0);
         cs_high();
         $display("[TB] frame 0x%0h -> rx_data=0x%0h count=%0d", vecs[k].data, rx_data, byte_count);
         check("tbl_valid", rx_valid, 1);
         check("tbl_data", rx_data, vecs[k].data);
         check("tbl_count", byte_count, vecs[k].exp_count);
         tick(3);
         check("tbl_data_hold", rx_data, vecs[k].data);
         pop_one();
         check("tbl_empty", rx_valid, 0);
      end
      pop_one();
      check("pop_empty_count", byte_count, 5);

      // ---- three bytes, consumer always ready ----
      do_reset();
      popped.delete();
      rx_ready = 1'b1;
      cs_low();
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      tick(4);
      check("stream_busy", busy, 1);
      cs_high();
      rx_ready = 1'b0;
      $display("[TB] stream 01,02,03 -> popped %0d bytes count=%0d", popped.size(), byte_count);
      check("stream_npop", popped.size(), 3);
      for (int i = 0; i < 3 && i < popped.size(); i++)
         check("stream_order", popped[i], i + 1);
      check("stream_count", byte_count, 3);
      check("stream_busy_end", busy, 0);

      // ---- overflow ----
      do_reset();
      cs_low();
      for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1'b0);
      cs_high();
      $display("[TB] overflow 10..14 -> overflow=%0d count=%0d", overflow, byte_count);
      check("ovf_flag", overflow, 1);
      check("ovf_count", byte_count, 4);
      clr_flags = 1'b1; tick(1); clr_flags = 1'b0;
      check("ovf_clr", overflow, 0);
      for (int i = 0; i < 4; i++) begin
         check("ovf_data", rx_data, 8'h10 + 8'(i));
         pop_one();
      end
      check("ovf_drained", rx_valid, 0);

      // ---- partial frame then good frame ----
      do_reset();
      cs_low();
      for (int i = 0; i < 3; i++) begin
         mosi_in = 1'b1; tick(4); sclk_in = 1'b1; tick(4); sclk_in = 1'b0;
      end
      cs_high();
      $display("[TB] partial frame -> frame_err=%0d valid=%0d", frame_err, rx_valid);
      check("ferr_flag", frame_err, 1);
      check("ferr_nopush", rx_valid, 0);
      check("ferr_count", byte_count, 0);
      cs_low();
      send_byte(8'h3C, 1'b0);
      cs_high();
      check("ferr_next_data", rx_data, 8'h3C);
      check("ferr_next_count", byte_count, 1);
      clr_flags = 1'b1; tick(1); clr_flags = 1'b0;
      check("ferr_clr", frame_err, 0);

      // ---- push and pop coincide on a full FIFO ----
      do_reset();
      cs_low();
      for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i), 1'b0);
      check("full_count", byte_count, 4);
      send_byte(8'h77, 1'b1);
      cs_high();
      $display("[TB] full push+pop 0x77 -> overflow=%0d count=%0d", overflow, byte_count);
      check("pp_overflow", overflow, 0);
      check("pp_count", byte_count, 5);
      for (int i = 1; i < 4; i++) begin
         check("pp_data", rx_data, 8'h20 + 8'(i));
         pop_one();
      end
      check("pp_last", rx_data, 8'h77);
      pop_one();
      check("pp_drained", rx_valid, 0);

      // ---- reset mid-frame ----
      do_reset();
      cs_low();
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      for (int i = 0; i < 3; i++) begin
         mosi_in = 1'b1; tick(4); sclk_in = 1'b1; tick(4); sclk_in = 1'b0;
      end
      rst_n = 1'b0;
      tick(1);
      check("mid_rst_valid", rx_valid, 0);
      check("mid_rst_data", rx_data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_count", byte_count, 0);
      cs_n_in = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(4);
      check("post_rst_busy", busy, 0);
      cs_low();
      send_byte(8'hC3, 1'b0);
      cs_high();
      $display("[TB] after reset 0xc3 -> rx_data=0x%0h count=%0d", rx_data, byte_count);
      check("post_rst_data", rx_data, 8'hC3);
      check("post_rst_count", byte_count, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_spi_sink
